alu_sequencer: RTL and testbench

- Multicycle control FSM for the simple-RISC datapath: register file, A/B/C pipeline registers, B-path shifter, 4-op ALU (ADD/SUB/AND/NOT-B), and status register.
- Holds the instruction register and decodes MOV/ALU instructions.
- Drives one datapath step per clock and reports completion via a start/wait handshake to the top level.

---
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multicycle control FSM for the simple-RISC datapath: holds the instruction register, decodes
// MOV/ALU instructions and drives one datapath step per clock behind a start/wait handshake.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StExec,
    StWriteReg,
    StWriteImm
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StWait;
      ir_q    <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    unique case (state_q)
      StWait: begin
        if (load) ir_d = in;
        if (s) begin
          state_d = StDecode;
          err_d   = 1'b0;
        end
      end
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWriteImm;
        end else if (is_mov_reg || is_mvn) begin
          state_d = StGetB;
        end else if (is_alu) begin
          state_d = StGetA;
        end else begin
          state_d = StWait;
          err_d   = 1'b1;
        end
      end
      StGetA:     state_d = StGetB;
      StGetB:     state_d = StExec;
      StExec:     state_d = is_cmp ? StWait : StWriteReg;
      StWriteReg: state_d = StWait;
      StWriteImm: state_d = StWait;
      default:    state_d = StWait;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    unique case (state_q)
      StWait: w = 1'b1;
      StDecode: ;
      StGetA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      StGetB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      StExec: begin
        shift = sh;
        // MOV reg passes B straight through as 0 + B.
        asel  = is_mov_reg;
        ALUop = is_mov_reg ? 2'b00 : op;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      StWriteReg: begin
        writenum = rd;
        write    = 1'b1;
      end
      StWriteImm: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign err    = err_q;
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer: one task per scenario with inline checks.
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;

  int total = 0;
  int bad   = 0;

  alu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .err      (err),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes packed as {write, loada, loadb, loadc, loads}.
  function automatic logic [4:0] strobes();
    return {write, loada, loadb, loadc, loads};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] word);
    in   = word;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    s    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in    = 16'hD0FB;
    load  = 1'b1;
    s     = 1'b0;
    #2;
    total++;
    if (w !== 1'b1) begin bad++; $display("FAIL reset_w got=%b exp=1", w); end
    total++;
    if (strobes() !== 5'b00000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=00000", strobes());
    end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    step();
    step();
    total++;
    if (sximm8 !== 16'h0000) begin
      bad++; $display("FAIL reset_ir_held got=%h exp=0000", sximm8);
    end
    reset = 1'b1;
    load  = 1'b0;
  endtask

  task automatic test_mov_imm();
    start(16'hD0FB);
    total++;
    if ({w, strobes()} !== 6'b000000) begin
      bad++; $display("FAIL movi_decode got=%b exp=000000", {w, strobes()});
    end
    step();
    total++;
    if ({w, strobes(), writenum, vsel} !== {1'b0, 5'b10000, 3'd0, 2'b10}) begin
      bad++; $display("FAIL movi_write got=%b exp=%b", {w, strobes(), writenum, vsel},
                      {1'b0, 5'b10000, 3'd0, 2'b10});
    end
    total++;
    if (sximm8 !== 16'hFFFB) begin bad++; $display("FAIL movi_sximm8 got=%h exp=FFFB", sximm8); end
    step();
    total++;
    if ({w, strobes()} !== 6'b100000) begin
      bad++; $display("FAIL movi_done got=%b exp=100000", {w, strobes()});
    end
  endtask

  task automatic test_add();
    start(16'hA148);
    step();
    total++;
    if ({w, readnum, strobes()} !== {1'b0, 3'd1, 5'b01000}) begin
      bad++; $display("FAIL add_get_a got=%b exp=%b", {w, readnum, strobes()},
                      {1'b0, 3'd1, 5'b01000});
    end
    step();
    total++;
    if ({readnum, strobes()} !== {3'd0, 5'b00100}) begin
      bad++; $display("FAIL add_get_b got=%b exp=%b", {readnum, strobes()}, {3'd0, 5'b00100});
    end
    step();
    total++;
    if ({shift, ALUop, asel, bsel, strobes()} !== {2'b01, 2'b00, 1'b0, 1'b0, 5'b00010}) begin
      bad++; $display("FAIL add_exec got=%b exp=%b", {shift, ALUop, asel, bsel, strobes()},
                      {2'b01, 2'b00, 1'b0, 1'b0, 5'b00010});
    end
    step();
    total++;
    if ({w, writenum, vsel, strobes()} !== {1'b0, 3'd2, 2'b00, 5'b10000}) begin
      bad++; $display("FAIL add_write got=%b exp=%b", {w, writenum, vsel, strobes()},
                      {1'b0, 3'd2, 2'b00, 5'b10000});
    end
    step();
    total++;
    if (w !== 1'b1) begin bad++; $display("FAIL add_latency got=%b exp=1", w); end
  endtask

  task automatic test_cmp();
    logic wrote;
    wrote = 1'b0;
    start(16'hA900);
    for (int i = 2; i <= 5; i++) begin
      if (write) wrote = 1'b1;
      if (i == 5) begin
        total++;
        if ({ALUop, loads, loadc} !== {2'b01, 1'b1, 1'b0}) begin
          bad++; $display("FAIL cmp_exec got=%b exp=0110", {ALUop, loads, loadc});
        end
      end
      step();
    end
    total++;
    if (w !== 1'b1) begin bad++; $display("FAIL cmp_latency got=%b exp=1", w); end
    total++;
    if (wrote !== 1'b0) begin bad++; $display("FAIL cmp_no_write got=%b exp=0", wrote); end
  endtask

  task automatic test_mvn();
    start(16'hB864);
    step();
    total++;
    if ({loada, loadb, readnum} !== {1'b0, 1'b1, 3'd4}) begin
      bad++; $display("FAIL mvn_get_b got=%b exp=01100", {loada, loadb, readnum});
    end
    step();
    total++;
    if ({ALUop, asel} !== {2'b11, 1'b0}) begin
      bad++; $display("FAIL mvn_exec got=%b exp=110", {ALUop, asel});
    end
    step();
    total++;
    if ({write, writenum} !== {1'b1, 3'd3}) begin
      bad++; $display("FAIL mvn_write got=%b exp=1011", {write, writenum});
    end
    step();
    total++;
    if (w !== 1'b1) begin bad++; $display("FAIL mvn_latency got=%b exp=1", w); end
  endtask

  task automatic test_mov_reg();
    start(16'hC0A3);
    step();
    total++;
    if ({loadb, readnum} !== {1'b1, 3'd3}) begin
      bad++; $display("FAIL movr_get_b got=%b exp=1011", {loadb, readnum});
    end
    step();
    total++;
    if ({asel, ALUop, loadc} !== {1'b1, 2'b00, 1'b1}) begin
      bad++; $display("FAIL movr_exec got=%b exp=1001", {asel, ALUop, loadc});
    end
    step();
    total++;
    if ({write, writenum} !== {1'b1, 3'd5}) begin
      bad++; $display("FAIL movr_write got=%b exp=1101", {write, writenum});
    end
    step();
    total++;
    if (w !== 1'b1) begin bad++; $display("FAIL movr_latency got=%b exp=1", w); end
  endtask

  task automatic test_illegal();
    start(16'h0000);
    total++;
    if ({w, err, strobes()} !== 7'b0000000) begin
      bad++; $display("FAIL ill_decode got=%b exp=0000000", {w, err, strobes()});
    end
    step();
    total++;
    if ({w, err, strobes()} !== 7'b1100000) begin
      bad++; $display("FAIL ill_done got=%b exp=1100000", {w, err, strobes()});
    end
    step();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", err); end
    start(16'hD0FB);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b exp=0", err); end
    step();
    step();
  endtask

  task automatic test_s_held();
    in   = 16'hD0FB;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    total++;
    if (w !== 1'b1) begin bad++; $display("FAIL held_wait got=%b exp=1", w); end
    step();
    total++;
    if (w !== 1'b0) begin bad++; $display("FAIL held_restart got=%b exp=0", w); end
    s = 1'b0;
    step();
    step();
    total++;
    if (w !== 1'b1) begin bad++; $display("FAIL held_finish got=%b exp=1", w); end
  endtask

  task automatic test_reset_mid();
    start(16'hA148);
    step();
    step();
    total++;
    if (loadb !== 1'b1) begin bad++; $display("FAIL mid_get_b got=%b exp=1", loadb); end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({w, loadb} !== 2'b10) begin
      bad++; $display("FAIL mid_reset got=%b exp=10", {w, loadb});
    end
    total++;
    if (sximm8 !== 16'h0000) begin bad++; $display("FAIL mid_ir got=%h exp=0000", sximm8); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_load_exec();
    start(16'hA148);
    step();
    step();
    step();
    in   = 16'hD0FB;
    load = 1'b1;
    s    = 1'b1;
    step();
    total++;
    if ({write, writenum} !== {1'b1, 3'd2}) begin
      bad++; $display("FAIL ldx_write got=%b exp=1010", {write, writenum});
    end
    load = 1'b0;
    s    = 1'b0;
    step();
    total++;
    if ({w, sximm8} !== {1'b1, 16'h0048}) begin
      bad++; $display("FAIL ldx_ir got=%b_%h exp=1_0048", w, sximm8);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn();
    test_mov_reg();
    test_illegal();
    test_s_held();
    test_reset_mid();
    test_load_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
